// File: rtl/top_print_msg.sv
// ---------------------------------------------------------------------------
// top_print_msg
// Repeatedly sends "Hello World!\r\n" on a UART TX line (8N1, LSB first),
// followed by GAP_BITS idle-high bit periods before the message repeats.
// A debug mux exposes internal registers on an 8-bit display port.
//
// Ports:
//   clk_100MHz    in   1  system clock, rising edge
//   nrst_i        in   1  synchronous active-low reset
//   uarttx_ser_o  out  1  UART serial TX (registered, idle high)
//   dbg_sel_i     in   4  debug view select
//   dbg_disp_o    out  8  selected debug value
//
// State table:
//   state  | meaning
//   IDLE   | after reset; leaves on the first edge out of reset
//   START  | start bit, line low for one bit period
//   DATA   | eight data bits, LSB first
//   STOP   | stop bit, line high; selects next byte or end of message
//   GAP    | GAP_BITS idle-high bit periods between messages
// ---------------------------------------------------------------------------
module top_print_msg #(
   parameter int BAUD_PER = 868,
   parameter int GAP_BITS = 2
) (
   input  logic       clk_100MHz,
   input  logic       nrst_i,
   output logic       uarttx_ser_o,
   input  logic [3:0] dbg_sel_i,
   output logic [7:0] dbg_disp_o
);

   // Baud counter is kept at least 8 bits wide so its low byte can always be
   // shown on the debug port.
   localparam int BW = ($clog2(BAUD_PER) > 8) ? $clog2(BAUD_PER) : 8;
   localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
   localparam logic [3:0] LAST_CHAR = 4'd13;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_GAP   = 3'd4
   } state_t;

   state_t        state, state_nxt;
   logic [3:0]    char_idx, char_idx_nxt;
   logic [2:0]    bit_idx, bit_idx_nxt;
   logic [BW-1:0] baud_cnt, baud_cnt_nxt;
   logic [GW-1:0] gap_cnt, gap_cnt_nxt;
   logic [7:0]    msg_cnt, msg_cnt_nxt;
   logic          tx_q, tx_nxt;
   logic [7:0]    cur_byte;
   logic          bit_end;
   logic          gap_last;

   function automatic logic [7:0] msg_byte(input logic [3:0] idx);
      case (idx)
         4'd0:    msg_byte = 8'h48;
         4'd1:    msg_byte = 8'h65;
         4'd2:    msg_byte = 8'h6C;
         4'd3:    msg_byte = 8'h6C;
         4'd4:    msg_byte = 8'h6F;
         4'd5:    msg_byte = 8'h20;
         4'd6:    msg_byte = 8'h57;
         4'd7:    msg_byte = 8'h6F;
         4'd8:    msg_byte = 8'h72;
         4'd9:    msg_byte = 8'h6C;
         4'd10:   msg_byte = 8'h64;
         4'd11:   msg_byte = 8'h21;
         4'd12:   msg_byte = 8'h0D;
         4'd13:   msg_byte = 8'h0A;
         default: msg_byte = 8'h00;
      endcase
   endfunction

   assign cur_byte = msg_byte(char_idx);
   assign bit_end  = (baud_cnt == BW'(BAUD_PER - 1));
   assign gap_last = (gap_cnt == GW'(GAP_BITS - 1));

   always_ff @(posedge clk_100MHz) begin
      if (!nrst_i) begin
         state    <= ST_IDLE;
         char_idx <= '0;
         bit_idx  <= '0;
         baud_cnt <= '0;
         gap_cnt  <= '0;
         msg_cnt  <= '0;
         tx_q     <= 1'b1;
      end else begin
         state    <= state_nxt;
         char_idx <= char_idx_nxt;
         bit_idx  <= bit_idx_nxt;
         baud_cnt <= baud_cnt_nxt;
         gap_cnt  <= gap_cnt_nxt;
         msg_cnt  <= msg_cnt_nxt;
         tx_q     <= tx_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      char_idx_nxt = char_idx;
      bit_idx_nxt  = bit_idx;
      gap_cnt_nxt  = gap_cnt;
      msg_cnt_nxt  = msg_cnt;
      baud_cnt_nxt = bit_end ? '0 : baud_cnt + 1'b1;
      tx_nxt       = 1'b1;

      // Line value follows the current state; the register adds the
      // one-cycle lag between a state change and the pin.
      case (state)
         ST_START: tx_nxt = 1'b0;
         ST_DATA:  tx_nxt = cur_byte[bit_idx];
         default:  tx_nxt = 1'b1;
      endcase

      case (state)
         ST_IDLE: begin
            state_nxt    = ST_START;
            char_idx_nxt = '0;
            bit_idx_nxt  = '0;
            baud_cnt_nxt = '0;
         end
         ST_START: begin
            if (bit_end) begin
               state_nxt   = ST_DATA;
               bit_idx_nxt = '0;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               bit_idx_nxt = bit_idx + 1'b1;
               if (bit_idx == 3'd7) begin
                  state_nxt = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               if (char_idx < LAST_CHAR) begin
                  char_idx_nxt = char_idx + 1'b1;
                  state_nxt    = ST_START;
               end else begin
                  char_idx_nxt = '0;
                  msg_cnt_nxt  = msg_cnt + 1'b1;
                  gap_cnt_nxt  = '0;
                  state_nxt    = (GAP_BITS == 0) ? ST_START : ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (bit_end) begin
               if (gap_last) begin
                  state_nxt = ST_START;
               end else begin
                  gap_cnt_nxt = gap_cnt + 1'b1;
               end
            end
         end
         default: begin
            state_nxt    = ST_IDLE;
            baud_cnt_nxt = '0;
         end
      endcase
   end

   assign uarttx_ser_o = tx_q;

   always_comb begin
      dbg_disp_o = 8'h00;
      case (dbg_sel_i)
         4'd0:    dbg_disp_o = cur_byte;
         4'd1:    dbg_disp_o = {4'b0, char_idx};
         4'd2:    dbg_disp_o = {5'b0, state};
         4'd3:    dbg_disp_o = {5'b0, bit_idx};
         4'd4:    dbg_disp_o = baud_cnt[7:0];
         4'd5:    dbg_disp_o = msg_cnt;
         4'd6:    dbg_disp_o = {7'b0, tx_q};
         default: dbg_disp_o = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_top_print_msg.sv
module tb_top_print_msg;

   logic       clk = 1'b0;
   logic       nrst = 1'b0;
   logic [3:0] dbg_sel = 4'd0;
   logic [3:0] sel_g0 = 4'd2;
   logic       tx, tx_g0;
   logic [7:0] disp, disp_g0;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [7:0] exp_q[$];
   logic [7:0] msg [14] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
                            8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0D, 8'h0A};

   top_print_msg #(.BAUD_PER(10), .GAP_BITS(2)) dut (
      .clk_100MHz(clk), .nrst_i(nrst), .uarttx_ser_o(tx),
      .dbg_sel_i(dbg_sel), .dbg_disp_o(disp));

   top_print_msg #(.BAUD_PER(10), .GAP_BITS(0)) dut_g0 (
      .clk_100MHz(clk), .nrst_i(nrst), .uarttx_ser_o(tx_g0),
      .dbg_sel_i(sel_g0), .dbg_disp_o(disp_g0));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic do_reset();
      nrst    = 1'b0;
      dbg_sel = 4'd0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [7:0] exp_v [7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
      do_reset();
      checks++;
      if (tx !== 1'b1) begin
         errors++; $display("FAIL reset_tx got=%b exp=1", tx);
      end
      for (int s = 1; s <= 6; s++) begin
         dbg_sel = s[3:0]; #1;
         checks++;
         if (disp !== exp_v[s]) begin
            errors++; $display("FAIL reset_sel%0d got=%h exp=%h", s, disp, exp_v[s]);
         end
      end
      dbg_sel = 4'd9; #1;
      checks++;
      if (disp !== 8'h00) begin
         errors++; $display("FAIL reset_sel9 got=%h exp=00", disp);
      end
      dbg_sel = 4'd0;
   endtask

   // Releases reset at the current negedge and checks the first frame ('H')
   // cycle by cycle. With toggle set, dbg_sel is scrambled every cycle.
   task automatic check_first_frame(input bit toggle);
      logic [7:0] h;
      logic       e;
      int         rel;
      h    = 8'h48;
      nrst = 1'b1;
      rel  = cyc;
      for (int k = 1; k <= 101; k++) begin
         @(negedge clk);
         if (k == 1)       e = 1'b1;
         else if (k <= 11) e = 1'b0;
         else if (k <= 91) e = h[(k - 12) / 10];
         else              e = 1'b1;
         checks++;
         if (tx !== e) begin
            errors++;
            $display("FAIL frame0_bit cycle=%0d toggle=%0d got=%b exp=%b", k, toggle, tx, e);
         end
         if (toggle) begin
            dbg_sel = 4'($urandom_range(0, 15));
         end else if (k == 5) begin
            dbg_sel = 4'd0; #1;
            checks++;
            if (disp !== 8'h48) begin
               errors++; $display("FAIL sel0_frame0 got=%h exp=48", disp);
            end
         end else if (k == 15) begin
            dbg_sel = 4'd2; #1;
            checks++;
            if (disp !== 8'h02) begin
               errors++; $display("FAIL sel2_data got=%h exp=02", disp);
            end
            dbg_sel = 4'd0;
         end
      end
      dbg_sel = 4'd0;
      if (cyc != rel + 101) $display("note: frame check cycle drift %0d", cyc - rel);
   endtask

   task automatic test_first_frame();
      do_reset();
      check_first_frame(1'b0);
   endtask

   task automatic test_sel_toggle();
      do_reset();
      check_first_frame(1'b1);
   endtask

   task automatic test_stream();
      int first, s, exp_start, waited;
      logic [7:0] got, expb;
      do_reset();
      for (int m = 0; m < 2; m++)
         for (int i = 0; i < 14; i++) exp_q.push_back(msg[i]);
      nrst  = 1'b1;
      first = cyc + 2;
      for (int k = 0; k < 28; k++) begin
         waited = 0;
         while (tx !== 1'b0 && waited < 300) begin
            @(negedge clk); waited++;
         end
         if (tx !== 1'b0) begin
            errors++; checks++;
            $display("FAIL stream_timeout byte=%0d got=%b exp=0", k, tx);
            return;
         end
         s = cyc;
         exp_start = (k < 14) ? first + 100 * k : first + 1420 + 100 * (k - 14);
         checks++;
         if (s != exp_start) begin
            errors++; $display("FAIL start_time byte=%0d got=%0d exp=%0d", k, s, exp_start);
         end
         repeat (4) @(negedge clk);
         checks++;
         if (tx !== 1'b0) begin
            errors++; $display("FAIL start_mid byte=%0d got=%b exp=0", k, tx);
         end
         if (k == 2) begin
            dbg_sel = 4'd1; #1;
            checks++;
            if (disp !== 8'h02) begin
               errors++; $display("FAIL sel1_frame2 got=%h exp=02", disp);
            end
         end
         if (k == 14) begin
            dbg_sel = 4'd5; #1;
            checks++;
            if (disp !== 8'h01) begin
               errors++; $display("FAIL sel5_msgcnt got=%h exp=01", disp);
            end
         end
         dbg_sel = 4'd0;
         for (int b = 0; b < 8; b++) begin
            repeat (10) @(negedge clk);
            got[b] = tx;
         end
         repeat (10) @(negedge clk);
         checks++;
         if (tx !== 1'b1) begin
            errors++; $display("FAIL stop_bit byte=%0d got=%b exp=1", k, tx);
         end
         if (k == 13) begin
            dbg_sel = 4'd1; #1;
            checks++;
            if (disp !== 8'h0D) begin
               errors++; $display("FAIL sel1_last got=%h exp=0d", disp);
            end
            dbg_sel = 4'd0;
         end
         expb = exp_q.pop_front();
         checks++;
         if (got !== expb) begin
            errors++; $display("FAIL byte%0d got=%h exp=%h", k, got, expb);
         end
      end
   endtask

   task automatic test_reset_mid();
      int first;
      logic [7:0] exp_v [7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
      do_reset();
      nrst  = 1'b1;
      first = cyc + 2;
      wait_cyc(first + 530);
      dbg_sel = 4'd1; #1;
      checks++;
      if (disp !== 8'h05) begin
         errors++; $display("FAIL mid_char5 got=%h exp=05", disp);
      end
      nrst = 1'b0;
      @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin
         errors++; $display("FAIL midreset_tx got=%b exp=1", tx);
      end
      for (int s = 1; s <= 6; s++) begin
         dbg_sel = s[3:0]; #1;
         checks++;
         if (disp !== exp_v[s]) begin
            errors++; $display("FAIL midreset_sel%0d got=%h exp=%h", s, disp, exp_v[s]);
         end
      end
      dbg_sel = 4'd0;
      repeat (5) @(negedge clk);
      check_first_frame(1'b0);
   endtask

   task automatic test_gap0();
      int first;
      do_reset();
      nrst  = 1'b1;
      first = cyc + 2;
      wait_cyc(first + 1399);
      checks++;
      if (tx_g0 !== 1'b1) begin
         errors++; $display("FAIL gap0_stop got=%b exp=1", tx_g0);
      end
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checks++;
         if (tx_g0 !== 1'b0) begin
            errors++; $display("FAIL gap0_start cycle=%0d got=%b exp=0", k, tx_g0);
         end
         if (k == 0) begin
            checks++;
            if (disp_g0 !== 8'h01) begin
               errors++; $display("FAIL gap0_state got=%h exp=01", disp_g0);
            end
            checks++;
            if (tx !== 1'b1) begin
               errors++; $display("FAIL gap2_idle got=%b exp=1", tx);
            end
         end
      end
      wait_cyc(first + 1419);
      checks++;
      if (tx !== 1'b1) begin
         errors++; $display("FAIL gap2_end got=%b exp=1", tx);
      end
      @(negedge clk);
      checks++;
      if (tx !== 1'b0) begin
         errors++; $display("FAIL gap2_restart got=%b exp=0", tx);
      end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_stream();
      test_reset_mid();
      test_gap0();
      test_sel_toggle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
